fb_write_arbiter: RTL and testbench

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

---
 rtl/fb_write_arbiter.sv | 166 ++++++++++++++++
 tb/tb_fb_write_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_arbiter.sv
// rtl/fb_write_arbiter.sv - two-requester framebuffer write arbiter with burst lock
//
// Purpose: arbitrates rasterizer (r_*) and CPU (c_*) pixel writes onto a single
// registered framebuffer write port. Round-robin on ties, optional burst lock
// with forced release after MAX_BURST locked transfers, sticky out-of-bounds flag.
//
// Ports:
//   clk, n_rst_async               clock, asynchronous active-low reset
//   r_valid/r_ready/r_addr/r_pixel/r_lock   rasterizer request channel
//   c_valid/c_ready/c_addr/c_pixel/c_lock   CPU request channel
//   fb_addr/fb_pixel/fb_write_en   registered framebuffer write port
//   owner                          requester of last accepted transfer (1 = CPU)
//   oob_error/clear_error          sticky out-of-bounds flag and its clear
module fb_write_arbiter #(
  parameter int A_WIDTH   = 16,
  parameter int D_WIDTH   = 3,
  parameter int FB_WORDS  = 34240,
  parameter int MAX_BURST = 64
) (
  input  logic               clk,
  input  logic               n_rst_async,
  input  logic               r_valid,
  output logic               r_ready,
  input  logic [A_WIDTH-1:0] r_addr,
  input  logic [D_WIDTH-1:0] r_pixel,
  input  logic               r_lock,
  input  logic               c_valid,
  output logic               c_ready,
  input  logic [A_WIDTH-1:0] c_addr,
  input  logic [D_WIDTH-1:0] c_pixel,
  input  logic               c_lock,
  output logic [A_WIDTH-1:0] fb_addr,
  output logic [D_WIDTH-1:0] fb_pixel,
  output logic               fb_write_en,
  output logic               owner,
  output logic               oob_error,
  input  logic               clear_error
);

  localparam int                 CNT_W      = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [A_WIDTH:0]   ADDR_LIMIT = (A_WIDTH + 1)'(FB_WORDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_R = 2'd1,
    LOCK_C = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_grant_q, last_grant_d;
  logic               fb_write_en_q, fb_write_en_d;
  logic [A_WIDTH-1:0] fb_addr_q, fb_addr_d;
  logic [D_WIDTH-1:0] fb_pixel_q, fb_pixel_d;
  logic               owner_q, owner_d;
  logic               oob_error_q, oob_error_d;

  logic               grant_r, grant_c;
  logic               lock_held, lock_is_c, at_max, xfer, continuing;
  logic               sel_c, sel_lock, sel_oob;
  logic [A_WIDTH-1:0] sel_addr;
  logic [D_WIDTH-1:0] sel_pixel;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_grant_d  = last_grant_q;
    fb_write_en_d = 1'b0;
    fb_addr_d     = fb_addr_q;
    fb_pixel_d    = fb_pixel_q;
    owner_d       = owner_q;
    oob_error_d   = oob_error_q;
    grant_r       = 1'b0;
    grant_c       = 1'b0;

    // A lock only counts while its owner keeps valid high; otherwise the
    // cycle is arbitrated exactly as if we were idle.
    lock_held = ((state_q == LOCK_R) && r_valid) || ((state_q == LOCK_C) && c_valid);
    lock_is_c = (state_q == LOCK_C);
    at_max    = (cnt_q == CNT_MAX);

    if (lock_held) begin
      if (!lock_is_c) begin
        if (at_max && c_valid) grant_c = 1'b1;
        else                   grant_r = 1'b1;
      end else begin
        if (at_max && r_valid) grant_r = 1'b1;
        else                   grant_c = 1'b1;
      end
    end else if (r_valid && c_valid) begin
      // last_grant_q = 1 means the CPU went last, so the rasterizer wins.
      grant_r = last_grant_q;
      grant_c = ~last_grant_q;
    end else begin
      grant_r = r_valid;
      grant_c = c_valid;
    end

    xfer       = grant_r | grant_c;
    sel_c      = grant_c;
    sel_addr   = sel_c ? c_addr  : r_addr;
    sel_pixel  = sel_c ? c_pixel : r_pixel;
    sel_lock   = sel_c ? c_lock  : r_lock;
    sel_oob    = ({1'b0, sel_addr} >= ADDR_LIMIT);
    continuing = lock_held && (sel_c == lock_is_c);

    if (xfer) begin
      last_grant_d  = sel_c;
      owner_d       = sel_c;
      fb_addr_d     = sel_addr;
      fb_pixel_d    = sel_pixel;
      fb_write_en_d = ~sel_oob;
      if (continuing && sel_lock) begin
        cnt_d = at_max ? cnt_q : cnt_q + CNT_ONE;
      end else if (sel_lock) begin
        // Fresh lock, either from idle or from a forced hand-over.
        state_d = sel_c ? LOCK_C : LOCK_R;
        cnt_d   = CNT_ONE;
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end else if (!lock_held) begin
      state_d = IDLE;
      cnt_d   = '0;
    end

    // Set has priority over clear.
    if (xfer && sel_oob)  oob_error_d = 1'b1;
    else if (clear_error) oob_error_d = 1'b0;
  end

  always_ff @(posedge clk or negedge n_rst_async) begin
    if (!n_rst_async) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      last_grant_q  <= 1'b1;
      fb_write_en_q <= 1'b0;
      fb_addr_q     <= '0;
      fb_pixel_q    <= '0;
      owner_q       <= 1'b0;
      oob_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_grant_q  <= last_grant_d;
      fb_write_en_q <= fb_write_en_d;
      fb_addr_q     <= fb_addr_d;
      fb_pixel_q    <= fb_pixel_d;
      owner_q       <= owner_d;
      oob_error_q   <= oob_error_d;
    end
  end

  // Ready is combinational from valid and grant, forced low during reset.
  assign r_ready     = grant_r & n_rst_async;
  assign c_ready     = grant_c & n_rst_async;
  assign fb_write_en = fb_write_en_q;
  assign fb_addr     = fb_addr_q;
  assign fb_pixel    = fb_pixel_q;
  assign owner       = owner_q;
  assign oob_error   = oob_error_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb/tb_fb_write_arbiter.sv - self-checking bench for fb_write_arbiter
module tb_fb_write_arbiter;

  localparam int AW = 16;
  localparam int DW = 3;
  localparam int FBW = 34240;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic r_valid, r_ready, r_lock, c_valid, c_ready, c_lock;
  logic [AW-1:0] r_addr, c_addr, fb_addr;
  logic [DW-1:0] r_pixel, c_pixel, fb_pixel;
  logic fb_write_en, owner, oob_error, clear_error;

  fb_write_arbiter #(.A_WIDTH(AW), .D_WIDTH(DW), .FB_WORDS(FBW), .MAX_BURST(MB)) dut (
    .clk(clk), .n_rst_async(rst_n),
    .r_valid(r_valid), .r_ready(r_ready), .r_addr(r_addr), .r_pixel(r_pixel), .r_lock(r_lock),
    .c_valid(c_valid), .c_ready(c_ready), .c_addr(c_addr), .c_pixel(c_pixel), .c_lock(c_lock),
    .fb_addr(fb_addr), .fb_pixel(fb_pixel), .fb_write_en(fb_write_en), .owner(owner),
    .oob_error(oob_error), .clear_error(clear_error)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who holds a lock (-1 none), how many locked transfers
  // it has done, who went last, and the expected registered outputs.
  int m_lock, m_cnt, m_last, m_owner;
  logic m_we, m_oob;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_pix;

  function automatic int m_grant();
    logic v [2];
    if (rst_n !== 1'b1) return -1;
    v[0] = r_valid;
    v[1] = c_valid;
    if (m_lock >= 0 && v[m_lock]) begin
      if (m_cnt == MB && v[1 - m_lock]) return 1 - m_lock;
      return m_lock;
    end
    if (v[0] && v[1]) return (m_last == 1) ? 0 : 1;
    if (v[0]) return 0;
    if (v[1]) return 1;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int g;
    logic [AW-1:0] a;
    logic lk;
    if (!rst_n) begin
      m_lock <= -1; m_cnt <= 0; m_last <= 1; m_owner <= 0;
      m_we <= 1'b0; m_oob <= 1'b0; m_addr <= '0; m_pix <= '0;
    end else begin
      g = m_grant();
      m_we <= 1'b0;
      if (g >= 0) begin
        a  = (g == 1) ? c_addr : r_addr;
        lk = (g == 1) ? c_lock : r_lock;
        m_addr  <= a;
        m_pix   <= (g == 1) ? c_pixel : r_pixel;
        m_owner <= g;
        m_last  <= g;
        m_we    <= (int'(a) < FBW);
        if (int'(a) >= FBW) m_oob <= 1'b1;
        else if (clear_error) m_oob <= 1'b0;
        if (lk && m_lock == g) m_cnt <= (m_cnt + 1 > MB) ? MB : m_cnt + 1;
        else if (lk) begin m_lock <= g; m_cnt <= 1; end
        else begin m_lock <= -1; m_cnt <= 0; end
      end else begin
        if (clear_error) m_oob <= 1'b0;
        m_lock <= -1;
        m_cnt  <= 0;
      end
    end
  end

  // Compare process: every negedge, DUT against the model.
  always @(negedge clk) begin
    int g;
    if (cmp_en) begin
      g = m_grant();
      chk("r_ready", r_ready, g == 0);
      chk("c_ready", c_ready, g == 1);
      chk("fb_write_en", fb_write_en, m_we);
      chk("fb_addr", fb_addr, m_addr);
      chk("fb_pixel", fb_pixel, m_pix);
      chk("owner", owner, m_owner[0]);
      chk("oob_error", oob_error, m_oob);
    end
  end

  task automatic set_in(input logic rv, input logic rl, input int ra, input int rp,
                        input logic cv, input logic cl, input int ca, input int cp);
    r_valid = rv; r_lock = rl; r_addr = AW'(ra); r_pixel = DW'(rp);
    c_valid = cv; c_lock = cl; c_addr = AW'(ca); c_pixel = DW'(cp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    clear_error = 1'b0;
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  int gnt_seq [6];
  int exp_seq [6] = '{0, 0, 0, 0, 1, 0};

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    clear_error = 1'b0;
    rst_n = 1'b0;
    #3;
    do_reset();
    cmp_en = 1'b1;

    // Reset values.
    @(negedge clk);
    chk("rst_we", fb_write_en, 0);
    chk("rst_addr", fb_addr, 0);
    chk("rst_owner", owner, 0);
    chk("rst_oob", oob_error, 0);

    // Round robin on ties, rasterizer first.
    next_cycle();
    set_in(1, 0, 5, 1, 1, 0, 6, 2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_grant_r", r_ready, (i % 2) == 0);
      chk("rr_grant_c", c_ready, (i % 2) == 1);
      if (i > 0) begin
        chk("rr_we", fb_write_en, 1);
        chk("rr_addr", fb_addr, (i % 2 == 1) ? 5 : 6);
      end
      next_cycle();
    end

    // Burst lock with forced release after MAX_BURST.
    do_reset();
    set_in(1, 1, 10, 3, 1, 0, 20, 4);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      gnt_seq[i] = r_ready ? 0 : (c_ready ? 1 : -1);
      next_cycle();
    end
    for (int i = 0; i < 6; i++) chk("burst_seq", gnt_seq[i], exp_seq[i]);

    // Out-of-bounds and boundary address.
    do_reset();
    set_in(0, 0, 0, 0, 1, 0, FBW, 5);
    @(negedge clk);
    chk("oob_ready", c_ready, 1);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("oob_we", fb_write_en, 0);
    chk("oob_flag", oob_error, 1);
    next_cycle();
    clear_error = 1'b1;
    next_cycle();
    clear_error = 1'b0;
    @(negedge clk);
    chk("oob_cleared", oob_error, 0);
    next_cycle();
    set_in(0, 0, 0, 0, 1, 0, FBW - 1, 3);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("edge_we", fb_write_en, 1);
    chk("edge_addr", fb_addr, FBW - 1);
    chk("edge_pix", fb_pixel, 3);

    // Lock lost when owner drops valid.
    do_reset();
    set_in(1, 1, 7, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("ll_r", r_ready, 1);
    next_cycle();
    set_in(0, 1, 7, 1, 1, 1, 8, 2);
    @(negedge clk);
    chk("ll_c", c_ready, 1);
    next_cycle();
    set_in(1, 1, 7, 1, 1, 1, 8, 2);
    @(negedge clk);
    chk("ll_c_locked", c_ready, 1);
    chk("ll_r_blocked", r_ready, 0);
    next_cycle();

    // Reset mid-burst right after an accepted transfer.
    do_reset();
    set_in(1, 1, 9, 6, 1, 1, 11, 7);
    next_cycle();
    next_cycle();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", fb_write_en, 0);
    chk("mid_rst_addr", fb_addr, 0);
    chk("mid_rst_ready", r_ready, 0);
    next_cycle();
    set_in(1, 0, 1, 1, 1, 0, 2, 2);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_tie", r_ready, 1);
    next_cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      int ra, ca;
      ra = (($urandom_range(0, 9) == 0) ? FBW + $urandom_range(0, 3) :
            ($urandom_range(0, 9) == 0) ? FBW - 1 - $urandom_range(0, 2) : $urandom_range(0, 1000));
      ca = (($urandom_range(0, 9) == 0) ? FBW + $urandom_range(0, 3) :
            ($urandom_range(0, 9) == 0) ? FBW - 1 - $urandom_range(0, 2) : $urandom_range(0, 1000));
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, ra, $urandom_range(0, 7),
             $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, ca, $urandom_range(0, 7));
      clear_error = ($urandom_range(0, 7) == 0);
      if (i == 700 || i == 1400) begin
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
      end
      next_cycle();
    end

    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
